// File: rtl/axi_bram_pkg.sv
// Shared types and helpers for the AXI4 burst BRAM slave.
// Burst/response encodings, FSM states and address stepping.
package axi_bram_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_BUSY
  } rstate_e;

  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Caller truncates the result to the memory depth.
  function automatic logic [31:0] next_word(
    input logic [31:0] addr,
    input logic [7:0]  len,
    input logic [1:0]  burst
  );
    logic [31:0] m;
    logic        wrap_ok;
    m       = {24'd0, len};
    wrap_ok = (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    if (burst == BURST_FIXED) return addr;
    if (burst == BURST_WRAP && wrap_ok)
      return (addr & ~m) | ((addr + 32'd1) & m);
    return addr + 32'd1;
  endfunction

endpackage

// File: rtl/axi_bram_burst_if.sv
// AXI4 memory-mapped bus bundle for the burst BRAM slave.
// master drives requests, slave drives ready/response.
interface axi_bram_burst_if #(
  parameter int AXI_IDWIDTH = 4,
  parameter int AXI_AWIDTH  = 64,
  parameter int AXI_DWIDTH  = 256
) ();
  logic                    awready;
  logic                    awvalid;
  logic [AXI_AWIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [1:0]              awburst;
  logic [AXI_IDWIDTH-1:0]  awid;

  logic                    wready;
  logic                    wvalid;
  logic                    wlast;
  logic [AXI_DWIDTH-1:0]   wdata;
  logic [AXI_DWIDTH/8-1:0] wstrb;

  logic                    bready;
  logic                    bvalid;
  logic [AXI_IDWIDTH-1:0]  bid;
  logic [1:0]              bresp;

  logic                    arready;
  logic                    arvalid;
  logic [AXI_AWIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [1:0]              arburst;
  logic [AXI_IDWIDTH-1:0]  arid;

  logic                    rready;
  logic                    rvalid;
  logic                    rlast;
  logic [AXI_DWIDTH-1:0]   rdata;
  logic [AXI_IDWIDTH-1:0]  rid;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awlen, awburst, awid,
    output wvalid, wlast, wdata, wstrb, bready,
    output arvalid, araddr, arlen, arburst, arid, rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rlast, rdata, rid, rresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, awburst, awid,
    input  wvalid, wlast, wdata, wstrb, bready,
    input  arvalid, araddr, arlen, arburst, arid, rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rlast, rdata, rid, rresp
  );
endinterface

// File: rtl/axi_bram_rskid.sv
// Two-entry read-return FIFO; decouples the BRAM pipeline
// from R-channel backpressure and reports occupancy.
module axi_bram_rskid
  import axi_bram_pkg::*;
#(
  parameter int DW  = 256,
  parameter int IDW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  logic [DW-1:0]  data_i,
  input  logic           last_i,
  input  logic [1:0]     resp_i,
  input  logic [IDW-1:0] id_i,
  input  logic           pop_i,
  output logic           valid_o,
  output logic [DW-1:0]  data_o,
  output logic           last_o,
  output logic [1:0]     resp_o,
  output logic [IDW-1:0] id_o,
  output logic [1:0]     count_o
);
  logic [1:0][DW-1:0]  data_q;
  logic [1:0]          last_q;
  logic [1:0][1:0]     resp_q;
  logic [1:0][IDW-1:0] id_q;
  logic                wr_q;
  logic                rd_q;
  logic [1:0]          count_q;
  logic                pop;

  assign pop = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      last_q  <= '0;
      resp_q  <= {RESP_OKAY, RESP_OKAY};
      id_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) begin
        data_q[wr_q] <= data_i;
        last_q[wr_q] <= last_i;
        resp_q[wr_q] <= resp_i;
        id_q[wr_q]   <= id_i;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop};
    end
  end

  assign valid_o = count_q != 2'd0;
  assign data_o  = data_q[rd_q];
  assign last_o  = valid_o && last_q[rd_q];
  assign resp_o  = resp_q[rd_q];
  assign id_o    = id_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/axi_bram_burst.sv
// AXI4 slave over an inferred BRAM with FIXED/INCR/WRAP bursts,
// DECERR on out-of-range starts and a stall-safe read pipeline.
module axi_bram_burst
  import axi_bram_pkg::*;
#(
  parameter int AXI_IDWIDTH = 4,
  parameter int AXI_AWIDTH  = 64,
  parameter int AXI_DWIDTH  = 256,
  parameter int MEM_AWIDTH  = 12
) (
  input logic clk,
  input logic rst,
  axi_bram_burst_if.slave s_axi
);
  localparam int NB    = AXI_DWIDTH / 8;
  localparam int OFF   = log2(NB);
  localparam int HI    = MEM_AWIDTH + OFF;
  localparam int DEPTH = 1 << MEM_AWIDTH;

  typedef logic [MEM_AWIDTH-1:0] word_t;

  wstate_e                wstate_q;
  logic                   awready_q, wready_q, bvalid_q;
  logic [AXI_IDWIDTH-1:0] bid_q;
  logic [1:0]             bresp_q;
  word_t                  waddr_q;
  logic [7:0]             wlen_q, wcnt_q;
  logic [1:0]             wburst_q;
  logic                   werr_q;

  rstate_e                rstate_q;
  logic                   arready_q;
  word_t                  raddr_q;
  logic [7:0]             rlen_q, rcnt_q;
  logic [1:0]             rburst_q;
  logic                   rerr_q;
  logic [AXI_IDWIDTH-1:0] rid_q;
  logic                   infl_q, infl_last_q, infl_err_q;

  logic [AXI_DWIDTH-1:0]  mem_q [DEPTH];
  logic [AXI_DWIDTH-1:0]  dout_q;

  logic                   w_beat, wr_en;
  logic                   r_issue, r_pop, r_drained;
  logic [1:0]             occ;
  logic [2:0]             credit;
  logic                   rvalid;
  logic                   rlast;
  logic [AXI_DWIDTH-1:0]  rdata;
  logic [AXI_IDWIDTH-1:0] rid;
  logic [1:0]             rresp;

  assign w_beat = s_axi.wvalid && wready_q;
  assign wr_en  = w_beat && !werr_q;

  // Occupancy plus in-flight read, less this cycle's pop, must leave room.
  assign r_pop     = rvalid && s_axi.rready;
  assign credit    = {1'b0, occ} + {2'b0, infl_q} - {2'b0, r_pop};
  assign r_issue   = (rstate_q == R_BUSY) && (credit < 3'd2);
  assign r_drained = !infl_q &&
                     (occ == 2'd0 || (occ == 2'd1 && r_pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: if (s_axi.awvalid) begin
          waddr_q   <= word_t'(s_axi.awaddr >> OFF);
          werr_q    <= (s_axi.awaddr >> HI) != '0;
          wlen_q    <= s_axi.awlen;
          wburst_q  <= s_axi.awburst;
          bid_q     <= s_axi.awid;
          wcnt_q    <= '0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          wstate_q  <= W_DATA;
        end
        W_DATA: if (w_beat) begin
          waddr_q <= word_t'(next_word(32'(waddr_q),
                                       wlen_q, wburst_q));
          wcnt_q  <= wcnt_q + 8'd1;
          if (s_axi.wlast || wcnt_q == wlen_q) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= werr_q ? RESP_DECERR : RESP_OKAY;
            wstate_q <= W_RESP;
          end
        end
        W_RESP: if (s_axi.bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wstate_q  <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q    <= R_IDLE;
      arready_q   <= 1'b1;
      raddr_q     <= '0;
      rlen_q      <= '0;
      rcnt_q      <= '0;
      rburst_q    <= '0;
      rerr_q      <= 1'b0;
      rid_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_err_q  <= 1'b0;
    end else begin
      infl_q      <= r_issue;
      infl_last_q <= r_issue && (rcnt_q == rlen_q);
      infl_err_q  <= rerr_q;
      case (rstate_q)
        R_IDLE: begin
          if (arready_q && s_axi.arvalid) begin
            raddr_q   <= word_t'(s_axi.araddr >> OFF);
            rerr_q    <= (s_axi.araddr >> HI) != '0;
            rlen_q    <= s_axi.arlen;
            rburst_q  <= s_axi.arburst;
            rid_q     <= s_axi.arid;
            rcnt_q    <= '0;
            arready_q <= 1'b0;
            rstate_q  <= R_BUSY;
          end else if (!arready_q && r_drained) begin
            arready_q <= 1'b1;
          end
        end
        R_BUSY: if (r_issue) begin
          raddr_q <= word_t'(next_word(32'(raddr_q),
                                       rlen_q, rburst_q));
          rcnt_q  <= rcnt_q + 8'd1;
          if (rcnt_q == rlen_q) rstate_q <= R_IDLE;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // Read-first: the registered read samples the pre-write word.
  always_ff @(posedge clk) begin
    if (r_issue) dout_q <= mem_q[raddr_q];
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (s_axi.wstrb[i])
          mem_q[waddr_q][i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
      end
    end
  end

  axi_bram_rskid #(
    .DW  (AXI_DWIDTH),
    .IDW (AXI_IDWIDTH)
  ) u_rskid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (infl_q),
    .data_i  (infl_err_q ? '0 : dout_q),
    .last_i  (infl_last_q),
    .resp_i  (infl_err_q ? RESP_DECERR : RESP_OKAY),
    .id_i    (rid_q),
    .pop_i   (s_axi.rready),
    .valid_o (rvalid),
    .data_o  (rdata),
    .last_o  (rlast),
    .resp_o  (rresp),
    .id_o    (rid),
    .count_o (occ)
  );

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rlast   = rlast;
  assign s_axi.rdata   = rdata;
  assign s_axi.rid     = rid;
  assign s_axi.rresp   = rresp;
endmodule

// File: tb/tb_axi_bram_burst.sv
// Directed bench for axi_bram_burst: bursts, DECERR,
// R backpressure, memory-end wrap and mid-burst reset.
module tb_axi_bram_burst;
  import axi_bram_pkg::*;

  localparam int DW  = 256;
  localparam int IDW = 4;
  localparam int AW  = 64;
  localparam int MAW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_bram_burst_if #(
    .AXI_IDWIDTH(IDW), .AXI_AWIDTH(AW), .AXI_DWIDTH(DW)
  ) axi ();

  axi_bram_burst #(
    .AXI_IDWIDTH(IDW), .AXI_AWIDTH(AW),
    .AXI_DWIDTH(DW), .MEM_AWIDTH(MAW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (axi)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0]  wbuf [16];
  logic [DW-1:0]  rdat [256];
  logic           rlst [256];
  logic [1:0]     rrsp [256];
  logic [IDW-1:0] rids [256];
  int             nb, lat, unstable, bwait;
  logic [1:0]     bresp_r;
  logic [IDW-1:0] bid_r;

  task automatic idle_inputs();
    axi.awvalid = 0; axi.awaddr = '0; axi.awlen = '0;
    axi.awburst = '0; axi.awid = '0;
    axi.wvalid = 0; axi.wlast = 0; axi.wdata = '0;
    axi.wstrb = '0; axi.bready = 0;
    axi.arvalid = 0; axi.araddr = '0; axi.arlen = '0;
    axi.arburst = '0; axi.arid = '0; axi.rready = 0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int len,
                          input logic [1:0] burst,
                          input logic [IDW-1:0] id,
                          input logic [DW/8-1:0] strb);
    int i, t;
    @(negedge clk);
    axi.awvalid = 1; axi.awaddr = addr; axi.awlen = 8'(len);
    axi.awburst = burst; axi.awid = id;
    t = 0;
    while (axi.awready !== 1'b1 && t < 100) begin
      @(negedge clk); t++;
    end
    i = 0; t = 0;
    while (i <= len && t < 500) begin
      @(negedge clk); t++;
      axi.awvalid = 0; axi.wvalid = 1; axi.wdata = wbuf[i];
      axi.wstrb = strb; axi.wlast = (i == len);
      if (axi.wready === 1'b1) i++;
    end
    n_chk++;
    if (i <= len) begin
      $display("FAIL wr_timeout: beats %0d required %0d", i, len + 1);
      n_fail++;
    end
    @(negedge clk);
    axi.wvalid = 0; axi.wlast = 0; axi.bready = 1;
    bwait = 0;
    while (axi.bvalid !== 1'b1 && bwait < 100) begin
      @(negedge clk); bwait++;
    end
    bresp_r = axi.bresp; bid_r = axi.bid;
    @(negedge clk);
    axi.bready = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int len,
                         input logic [1:0] burst,
                         input logic [IDW-1:0] id, input bit rnd);
    int t, cyc;
    logic stall;
    logic [DW-1:0] pdata;
    logic plast;
    logic [1:0] presp;
    nb = 0; lat = -1; unstable = 0; stall = 0;
    pdata = '0; plast = 0; presp = '0;
    @(negedge clk);
    axi.arvalid = 1; axi.araddr = addr; axi.arlen = 8'(len);
    axi.arburst = burst; axi.arid = id;
    t = 0;
    while (axi.arready !== 1'b1 && t < 100) begin
      @(negedge clk); t++;
    end
    cyc = 0;
    while (nb <= len && cyc < 2000) begin
      @(negedge clk); cyc++;
      axi.arvalid = 0;
      if (axi.rvalid === 1'b1 && lat < 0) lat = cyc - 1;
      if (stall && (axi.rvalid !== 1'b1 || axi.rdata !== pdata ||
                    axi.rlast !== plast || axi.rresp !== presp))
        unstable++;
      axi.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = axi.rvalid && !axi.rready;
      pdata = axi.rdata; plast = axi.rlast; presp = axi.rresp;
      if (axi.rvalid === 1'b1 && axi.rready) begin
        rdat[nb] = axi.rdata; rlst[nb] = axi.rlast;
        rrsp[nb] = axi.rresp; rids[nb] = axi.rid;
        nb++;
      end
    end
    n_chk++;
    if (nb != len + 1) begin
      $display("FAIL rd_timeout: beats %0d required %0d", nb, len + 1);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({axi.awready, axi.arready, axi.wready, axi.bvalid,
         axi.rvalid, axi.rlast} !== 6'b110000) begin
      $display("FAIL reset_ctl: got %b required 110000",
               {axi.awready, axi.arready, axi.wready, axi.bvalid,
                axi.rvalid, axi.rlast});
      n_fail++;
    end
    n_chk++;
    if ({axi.bid, axi.bresp, axi.rid, axi.rresp} !== '0) begin
      $display("FAIL reset_ids: got %h required 0",
               {axi.bid, axi.bresp, axi.rid, axi.rresp});
      n_fail++;
    end
    n_chk++;
    if (axi.rdata !== '0) begin
      $display("FAIL reset_rdata: got %h required 0", axi.rdata);
      n_fail++;
    end
    rst = 0;
    @(negedge clk);
    n_chk++;
    if ({axi.awready, axi.arready} !== 2'b11) begin
      $display("FAIL reset_rel: got %b required 11",
               {axi.awready, axi.arready});
      n_fail++;
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) wbuf[i] = DW'(i + 1);
    do_write(64'h40, 3, BURST_INCR, 4'h5, '1);
    n_chk++;
    if ({bresp_r, bid_r} !== {RESP_OKAY, 4'h5} || bwait != 0) begin
      $display("FAIL incr_b: got resp %b id %h wait %0d required 00 5 0",
               bresp_r, bid_r, bwait);
      n_fail++;
    end
    do_read(64'h40, 3, BURST_INCR, 4'hA, 0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({rdat[i], rlst[i], rrsp[i], rids[i]} !==
          {DW'(i + 1), (i == 3), RESP_OKAY, 4'hA}) begin
        $display("FAIL incr_r%0d: got %h l%b r%b id%h required %0d l%b",
                 i, rdat[i], rlst[i], rrsp[i], rids[i], i + 1, i == 3);
        n_fail++;
      end
    end
    n_chk++;
    if (lat != 2) begin
      $display("FAIL rd_latency: got %0d required 2", lat);
      n_fail++;
    end
  endtask

  task automatic test_wrap();
    int e3 [3];
    int e4 [4];
    int e11 [4];
    e4 = '{6, 7, 4, 5};
    e3 = '{6, 7, 8};
    e11 = '{6, 7, 8, 9};
    for (int i = 0; i < 16; i++) wbuf[i] = DW'(i);
    do_write(64'h0, 15, BURST_INCR, 4'h0, '1);
    do_read(64'hC0, 3, BURST_WRAP, 4'h1, 0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({rdat[i], rlst[i]} !== {DW'(e4[i]), (i == 3)}) begin
        $display("FAIL wrap4_r%0d: got %h l%b required %0d",
                 i, rdat[i], rlst[i], e4[i]);
        n_fail++;
      end
    end
    do_read(64'hC0, 2, BURST_WRAP, 4'h1, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (rdat[i] !== DW'(e3[i])) begin
        $display("FAIL wrap_len2_r%0d: got %h required %0d",
                 i, rdat[i], e3[i]);
        n_fail++;
      end
    end
    do_read(64'hC0, 3, 2'b11, 4'h1, 0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (rdat[i] !== DW'(e11[i])) begin
        $display("FAIL burst11_r%0d: got %h required %0d",
                 i, rdat[i], e11[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_fixed();
    wbuf[0] = DW'(32'hA); wbuf[1] = DW'(32'hB);
    wbuf[2] = DW'(32'hCCCC_CCCC);
    do_write(64'h120, 2, BURST_FIXED, 4'h1, '1);
    do_read(64'h120, 2, BURST_FIXED, 4'h2, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (rdat[i] !== DW'(32'hCCCC_CCCC)) begin
        $display("FAIL fixed_r%0d: got %h required cccccccc",
                 i, rdat[i]);
        n_fail++;
      end
    end
    do_read(64'h140, 0, BURST_INCR, 4'h2, 0);
    n_chk++;
    if (rdat[0] !== DW'(10)) begin
      $display("FAIL fixed_nb: got %h required a", rdat[0]);
      n_fail++;
    end
    wbuf[0] = {32{8'hAB}};
    do_write(64'h120, 0, BURST_INCR, 4'h2, 32'h1);
    do_read(64'h120, 0, BURST_INCR, 4'h2, 0);
    n_chk++;
    if (rdat[0] !== DW'(32'hCCCC_CCAB)) begin
      $display("FAIL strb: got %h required ccccccab", rdat[0]);
      n_fail++;
    end
  endtask

  task automatic test_decerr();
    logic [AW-1:0] bad;
    bad = 64'd1 << (MAW + 5);
    do_read(bad, 1, BURST_INCR, 4'h3, 0);
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if ({rdat[i], rlst[i], rrsp[i]} !==
          {DW'(0), (i == 1), RESP_DECERR}) begin
        $display("FAIL decerr_r%0d: got %h l%b r%b required 0 l%b 11",
                 i, rdat[i], rlst[i], rrsp[i], i == 1);
        n_fail++;
      end
    end
    wbuf[0] = DW'(32'hDEAD); wbuf[1] = DW'(32'hBEEF);
    do_write(bad, 1, BURST_INCR, 4'h4, '1);
    n_chk++;
    if (bresp_r !== RESP_DECERR) begin
      $display("FAIL decerr_b: got %b required 11", bresp_r);
      n_fail++;
    end
    do_read(64'h0, 1, BURST_INCR, 4'h3, 0);
    n_chk++;
    if ({rdat[0], rdat[1]} !== {DW'(0), DW'(1)}) begin
      $display("FAIL decerr_mem: got %h %h required 0 1",
               rdat[0], rdat[1]);
      n_fail++;
    end
  endtask

  task automatic test_random_rready();
    int lasts, extra;
    do_read(64'h0, 15, BURST_INCR, 4'h7, 1);
    lasts = 0;
    for (int i = 0; i < 16; i++) begin
      lasts += int'(rlst[i]);
      n_chk++;
      if ({rdat[i], rlst[i]} !==
          {(i == 9) ? DW'(32'hCCCC_CCAB) : DW'(i), (i == 15)}) begin
        $display("FAIL rnd_r%0d: got %h l%b", i, rdat[i], rlst[i]);
        n_fail++;
      end
    end
    n_chk++;
    if (lasts != 1 || unstable != 0) begin
      $display("FAIL rnd_stall: lasts %0d unstable %0d required 1 0",
               lasts, unstable);
      n_fail++;
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      axi.rready = 1;
      if (axi.rvalid === 1'b1) extra++;
    end
    n_chk++;
    if (extra != 0) begin
      $display("FAIL rnd_extra: got %0d beats required 0", extra);
      n_fail++;
    end
  endtask

  task automatic test_mem_wrap();
    wbuf[0] = DW'(32'h77); wbuf[1] = DW'(32'h88);
    do_write(64'(4095 * 32), 1, BURST_INCR, 4'h1, '1);
    do_read(64'(4095 * 32), 1, BURST_INCR, 4'h1, 0);
    n_chk++;
    if ({rdat[0], rdat[1]} !== {DW'(32'h77), DW'(32'h88)}) begin
      $display("FAIL memwrap: got %h %h required 77 88",
               rdat[0], rdat[1]);
      n_fail++;
    end
    do_read(64'h0, 0, BURST_INCR, 4'h1, 0);
    n_chk++;
    if (rdat[0] !== DW'(32'h88)) begin
      $display("FAIL memwrap_w0: got %h required 88", rdat[0]);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int t, spur;
    @(negedge clk);
    axi.arvalid = 1; axi.araddr = '0; axi.arlen = 8'd7;
    axi.arburst = BURST_INCR; axi.arid = 4'h6; axi.rready = 0;
    t = 0;
    while (axi.arready !== 1'b1 && t < 100) begin
      @(negedge clk); t++;
    end
    @(negedge clk);
    axi.arvalid = 0;
    axi.awvalid = 1; axi.awaddr = 64'(100 * 32); axi.awlen = 8'd3;
    axi.awburst = BURST_INCR; axi.awid = 4'h7;
    t = 0;
    while (axi.awready !== 1'b1 && t < 100) begin
      @(negedge clk); t++;
    end
    @(negedge clk);
    axi.awvalid = 0; axi.wvalid = 1; axi.wstrb = '1;
    axi.wdata = DW'(1); axi.wlast = 0;
    @(negedge clk); axi.wdata = DW'(2);
    @(negedge clk); axi.wdata = DW'(3);
    n_chk++;
    if ({axi.wready, axi.rvalid} !== 2'b11) begin
      $display("FAIL mid_pre: got %b required 11",
               {axi.wready, axi.rvalid});
      n_fail++;
    end
    rst = 1;
    #1;
    n_chk++;
    if ({axi.wready, axi.bvalid, axi.rvalid, axi.rlast} !== 4'b0) begin
      $display("FAIL mid_drop: got %b required 0000",
               {axi.wready, axi.bvalid, axi.rvalid, axi.rlast});
      n_fail++;
    end
    @(negedge clk);
    idle_inputs();
    rst = 0;
    axi.rready = 1; axi.bready = 1;
    spur = 0;
    repeat (10) begin
      @(negedge clk);
      if (axi.bvalid === 1'b1 || axi.rvalid === 1'b1) spur++;
    end
    n_chk++;
    if (spur != 0 || {axi.awready, axi.arready} !== 2'b11) begin
      $display("FAIL mid_after: spurious %0d rdy %b required 0 11",
               spur, {axi.awready, axi.arready});
      n_fail++;
    end
    axi.bready = 0;
    do_read(64'h0, 0, BURST_INCR, 4'h2, 0);
    n_chk++;
    if ({rdat[0], rrsp[0]} !== {DW'(32'h88), RESP_OKAY}) begin
      $display("FAIL mid_recover: got %h required 88", rdat[0]);
      n_fail++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_decerr();
    test_random_rready();
    test_mem_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
